// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants and the fetch-queue entry layout.
package mips_pkg;

    localparam int          DATA_WIDTH       = 32;
    localparam logic [5:0]  OP_J             = 6'h02;
    localparam logic [5:0]  OP_JAL           = 6'h03;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic        predicted;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Generic show-ahead FIFO with a one-cycle flush; head data reads zero while empty.
module fetch_fifo #(
    parameter  int WIDTH = 97,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign pop_en  = pop & (count_q != '0);
    assign push_en = push & ((count_q != CNT_W'(DEPTH)) | pop_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: PC register, next-PC selection and a show-ahead fetch queue.
// Optional J predecode is enabled by defining FETCH_JUMP_PREDECODE_EN.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter  int          DATA_WIDTH  = mips_pkg::DATA_WIDTH,
    parameter  int          QUEUE_DEPTH = 4,
    parameter  logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    localparam int          CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    input  logic                  redirect_valid_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus_4_o,
    output logic                  instr_predicted_o,
    output logic [CNT_W-1:0]      queue_count_o
);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         predicted;
    logic         push;
    logic         pop;
    logic [CNT_W-1:0] count;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic         unused_redirect_lsb;

    assign pc_plus4 = pc_q + PC_STEP;

`ifdef FETCH_JUMP_PREDECODE_EN
    // JAL still goes through EX so the link register write happens there.
    always_comb begin
        predicted = (imem_data_i[31:26] == OP_J);
        next_pc   = predicted ? {pc_plus4[31:28], imem_data_i[25:0], 2'b00} : pc_plus4;
    end
`else
    always_comb begin
        predicted = 1'b0;
        next_pc   = pc_plus4;
    end
`endif

    assign pop  = instr_valid_o & instr_ready_i;
    assign push = ~redirect_valid_i & ((count < CNT_W'(QUEUE_DEPTH)) | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (push) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        push_entry           = '0;
        push_entry.predicted = predicted;
        push_entry.pc        = pc_q;
        push_entry.pc_plus_4 = pc_plus4;
        push_entry.instr     = imem_data_i;
    end

    fetch_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid_i),
        .data_i  (push_entry),
        .data_o  (head_entry),
        .count_o (count)
    );

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    assign imem_addr_o       = pc_q;
    assign instr_valid_o     = (count != '0);
    assign instr_o           = head_entry.instr;
    assign pc_o              = head_entry.pc;
    assign pc_plus_4_o       = head_entry.pc_plus_4;
    assign instr_predicted_o = head_entry.predicted;
    assign queue_count_o     = count;

endmodule
